// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the seven-segment refresh logic.
//   NUM_DIGITS - digits on the multiplexed display
//   BRIGHT_MAX - highest brightness code (continuous on)
//   PWM_PERIOD - length of one brightness PWM cycle in clocks
//   AN_OFF     - anode bus value with every digit dark (anodes are active-low)
//   phase_t    - per-slot phase: BLANK gap, then DRIVE
package display_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int BRIGHT_MAX = 15;
    localparam int PWM_PERIOD = 15;

    localparam logic [7:0] AN_OFF = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } phase_t;

endpackage

// File: rtl/dimmer_pwm.sv
// dimmer_pwm: mod-PWM_PERIOD brightness counter with synchronous clear.
//   clk, reset - system clock, asynchronous active-high reset
//   clear      - force the count to 0 at the next edge (held while blanking)
//   advance    - step the count by one, wrapping PWM_PERIOD-1 -> 0
//   bright     - brightness code 0..15
//   on         - cnt < bright, evaluated for the count the next cycle holds
module dimmer_pwm
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [3:0] bright,
    output logic       on
);

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_nxt = cnt;
        if (clear) begin
            cnt_nxt = '0;
        end else if (advance) begin
            cnt_nxt = (cnt == 4'(PWM_PERIOD - 1)) ? '0 : cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Compared against the upcoming count so the caller can register the
    // anode in the same edge that moves the counter; both then line up.
    // Since cnt never exceeds 14, bright = 15 is continuously on.
    assign on = (cnt_nxt < bright);

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: refresh scheduler for an 8-digit multiplexed 7-segment
// display. Each slot is a BLANK gap (all anodes off), then a DRIVE window in
// which the slot's anode is pulse-width modulated by brightness and gated by
// the digit enable mask. New configuration is accepted into a one-entry
// pending buffer and promoted only where slot 7 wraps to slot 0.
//   clk, reset    - system clock, asynchronous active-high reset
//   cfg_valid     - configuration offered
//   cfg_ready     - pending buffer empty, configuration can be taken
//   cfg_digit_en  - digit enable mask, bit i enables digit i
//   cfg_bright    - brightness 0 (off) .. 15 (full on)
//   seg_sel       - current digit index for the segment-data mux
//   An            - active-low anode enables, at most one bit low
//   frame_start   - one-cycle pulse in the first cycle of slot 0
module display_scheduler
    import display_pkg::*;
#(
    parameter int TICKS_PER_SLOT = 100000,
    parameter int BLANK_TICKS    = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_digit_en,
    input  logic [3:0] cfg_bright,
    output logic [2:0] seg_sel,
    output logic [7:0] An,
    output logic       frame_start
);

    localparam int TW = $clog2(TICKS_PER_SLOT);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SLOT - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
    localparam logic [2:0]    SLOT_LAST  = 3'(NUM_DIGITS - 1);

    logic [TW-1:0] tick;
    logic [2:0]    slot;
    phase_t        phase;
    logic [7:0]    act_en;
    logic [3:0]    act_br;
    logic [7:0]    pend_en;
    logic [3:0]    pend_br;
    logic          pend_full;

    logic [TW-1:0] tick_nxt;
    logic [2:0]    slot_nxt;
    phase_t        phase_nxt;
    logic          boundary;
    logic          take_cfg;
    logic          pend_full_nxt;
    logic          dim_on;
    logic [7:0]    an_nxt;

    // The counter is held cleared through BLANK, so it is 0 in the first
    // DRIVE cycle and steps once per DRIVE cycle after that.
    dimmer_pwm u_dimmer (
        .clk     (clk),
        .reset   (reset),
        .clear   (phase == BLANK),
        .advance (phase == DRIVE),
        .bright  (act_br),
        .on      (dim_on)
    );

    always_comb begin
        tick_nxt  = (tick == TICK_LAST) ? '0 : tick + TW'(1);
        slot_nxt  = slot;
        phase_nxt = phase;
        case (phase)
            BLANK:   if (tick == BLANK_LAST) phase_nxt = DRIVE;
            DRIVE:   if (tick == TICK_LAST) begin
                         phase_nxt = BLANK;
                         slot_nxt  = slot + 3'd1;
                     end
            default: phase_nxt = BLANK;
        endcase

        boundary = (phase == DRIVE) && (tick == TICK_LAST) && (slot == SLOT_LAST);
        take_cfg = cfg_valid && cfg_ready;

        // A boundary always empties the buffer (promoting it if full); a
        // transfer in the same cycle can only happen when it was already
        // empty, so it refills it and waits for the following boundary.
        pend_full_nxt = pend_full;
        if (boundary) pend_full_nxt = 1'b0;
        if (take_cfg) pend_full_nxt = 1'b1;

        // Anode for the cycle after this edge, so An is a plain register.
        an_nxt = AN_OFF;
        if (phase_nxt == DRIVE && act_en[slot_nxt] && dim_on) begin
            an_nxt[slot_nxt] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick        <= '0;
            slot        <= '0;
            phase       <= BLANK;
            act_en      <= 8'hFF;
            act_br      <= 4'(BRIGHT_MAX);
            pend_en     <= '0;
            pend_br     <= '0;
            pend_full   <= 1'b0;
            cfg_ready   <= 1'b1;
            An          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            tick        <= tick_nxt;
            slot        <= slot_nxt;
            phase       <= phase_nxt;
            An          <= an_nxt;
            frame_start <= boundary;
            if (boundary && pend_full) begin
                act_en <= pend_en;
                act_br <= pend_br;
            end
            if (take_cfg) begin
                pend_en <= cfg_digit_en;
                pend_br <= cfg_bright;
            end
            pend_full <= pend_full_nxt;
            cfg_ready <= !pend_full_nxt;
        end
    end

    // slot is itself a register, so seg_sel is registered and stays stable
    // across BLANK while the segment data settles.
    assign seg_sel = slot;

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed bench for display_scheduler with a short
// slot (20 cycles, 4 blank). Every cycle the anode bus, digit select,
// frame pulse and ready are compared against values derived from the
// bench's own view of which configuration is active.
module tb_display_scheduler;

    localparam int TPS   = 20;
    localparam int BLK   = 4;
    localparam int FRAME = 8 * TPS;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_digit_en = '0;
    logic [3:0] cfg_bright = '0;
    logic       cfg_ready;
    logic [2:0] seg_sel;
    logic [7:0] An;
    logic       frame_start;

    display_scheduler #(
        .TICKS_PER_SLOT (TPS),
        .BLANK_TICKS    (BLK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_digit_en (cfg_digit_en),
        .cfg_bright   (cfg_bright),
        .seg_sel      (seg_sel),
        .An           (An),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] en;
        logic [3:0] br;
    } cfg_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    cfg_t offers[$];

    // Expected state: active and pending configuration
    logic [7:0] m_en;
    logic [3:0] m_br;
    logic [7:0] m_pen;
    logic [3:0] m_pbr;
    logic       m_pf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Anode pattern for a cycle counted from reset release.
    function automatic logic [7:0] exp_an(input int c, input logic [7:0] en, input logic [3:0] br);
        int pos;
        int s;
        int t;
        logic [7:0] a;
        pos = c % FRAME;
        s   = pos / TPS;
        t   = pos % TPS;
        a   = 8'hFF;
        if (t >= BLK && en[s] && ((t - BLK) % 15) < int'(br)) a[s] = 1'b0;
        return a;
    endfunction

    task automatic model_reset();
        m_en  = 8'hFF;
        m_br  = 4'd15;
        m_pen = '0;
        m_pbr = '0;
        m_pf  = 1'b0;
        cyc   = 0;
    endtask

    // Check the current cycle, present the head offer, advance the model
    // across the edge, then step to 1 time unit after the next rising edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            int   pos;
            logic rdy;
            pos = cyc % FRAME;
            check("an", An, exp_an(cyc, m_en, m_br));
            check("seg_sel", seg_sel, pos / TPS);
            check("frame_start", frame_start, (pos == 0 && cyc != 0));
            check("cfg_ready", cfg_ready, !m_pf);

            cfg_valid = (offers.size() > 0);
            if (cfg_valid) begin
                cfg_digit_en = offers[0].en;
                cfg_bright   = offers[0].br;
            end

            rdy = !m_pf;
            if (pos == FRAME - 1 && m_pf) begin
                m_en = m_pen;
                m_br = m_pbr;
                m_pf = 1'b0;
            end
            if (cfg_valid && rdy) begin
                m_pen = offers[0].en;
                m_pbr = offers[0].br;
                m_pf  = 1'b1;
                void'(offers.pop_front());
            end

            @(posedge clk);
            #1;
            cyc++;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic offer(input logic [7:0] en, input logic [3:0] br);
        cfg_t c;
        c.en = en;
        c.br = br;
        offers.push_back(c);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_an", An, 8'hFF);
        check("rst_seg_sel", seg_sel, 3'd0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        reset = 1'b0;

        // Default config: all digits, full brightness; first frame unflagged.
        run(170);

        // Mask 1010_1010 offered mid-frame, active from the next slot 0.
        offer(8'b1010_1010, 4'd15);
        run(310);

        // Brightness 5, then brightness 0.
        offer(8'hFF, 4'd5);
        run(320);
        offer(8'hFF, 4'd0);
        run(350);

        // Back-to-back: the second waits until the first is promoted.
        offer(8'h0F, 4'd15);
        offer(8'hF0, 4'd7);
        run(450);

        // Transfer in the slot-7-to-slot-0 cycle applies one frame later.
        run(159);
        offer(8'h3C, 4'd10);
        run(321);

        // Leave a config pending, then reset during slot 5 DRIVE.
        offer(8'h00, 4'd3);
        run(110);
        check("pre_reset_an", An, 8'hDF);
        reset = 1'b1;
        #1;
        check("async_an", An, 8'hFF);
        check("async_seg_sel", seg_sel, 3'd0);
        check("async_cfg_ready", cfg_ready, 1'b1);
        check("async_frame_start", frame_start, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        offers.delete();
        model_reset();

        // Pending config must be gone: defaults through the next boundary.
        run(170);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Refresh scheduler for the 8-digit multiplexed seven-segment display. It times each digit slot, steps the 3-bit digit select and drives the active-low anode bus. It inserts an anti-ghosting blank gap before each digit and applies per-digit enable masking and 16-level brightness PWM. Configuration arrives over a valid/ready handshake and takes effect only at frame boundaries, so a frame never mixes old and new settings.

## Interface
- TICKS_PER_SLOT, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be > BLANK_TICKS.
- BLANK_TICKS, 1000: cycles at the start of each slot with all anodes off; ≥ 1.
- clk  in  1  system clock.
- reset  in  1  reset; one clock; reset is asynchronous and active-high.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  scheduler can accept configuration.
- cfg_digit_en  in  8  digit enable mask; bit i enables digit i.
- cfg_bright  in  4  brightness 0 (off) … 15 (full on).
- seg_sel  out  3  current digit index, drives the segment-data mux.
- An  out  8  anode enables, active-low, at most one bit low.
- frame_start  out  1  one-cycle pulse in the first cycle of slot 0.

## Operation
- Registers:
  - slot counter `tick` 0..TICKS_PER_SLOT-1.
  - digit index `slot` 0..7.
  - phase state BLANK/DRIVE.
  - PWM counter `pwm` 0..14, mod 15.
  - active config `act_en` and `act_br`.
  - pending config `pend_en`, `pend_br`, `pend_full`.
- State machine:
  - BLANK: An = 8'hFF. When `tick` == BLANK_TICKS-1, go to DRIVE.
  - DRIVE: An[slot] = 0 iff act_en[slot] && (pwm < act_br); all other bits are 1.
  - DRIVE exit: when `tick` == TICKS_PER_SLOT-1, go to BLANK, `tick` → 0, `slot` → slot+1 mod 8.
- `pwm` increments every DRIVE cycle and wraps 14→0. It is cleared on entry to DRIVE. act_br=15 gives continuous on; act_br=0 gives always off.
- seg_sel = `slot` for the whole slot, including BLANK, so segment data settles before the anode turns on.
- Frame boundary is the cycle in which `slot` wraps 7→0. In that cycle:
  - if pend_full, then act ← pend and pend_full ← 0.
  - frame_start pulses in the next cycle, the first cycle of slot 0.
- Handshake:
  - cfg_ready = !pend_full.
  - Transfer occurs on cfg_valid && cfg_ready at a rising clock edge: pend ← cfg, pend_full ← 1.
  - Only one pending entry exists; a later config waits for cfg_ready.
- Simultaneous transfer and frame boundary: the boundary promotes the old pending state, which is empty. The new transfer sets pend_full and applies at the following boundary.
- Reset values:
  - seg_sel = 0, An = 8'hFF, frame_start = 0, cfg_ready = 1.
  - state BLANK, tick = 0, slot = 0, pwm = 0.
  - act_en = 8'hFF, act_br = 15, pend_full = 0.
- Reset mid-slot blanks the display asynchronously (An = 8'hFF immediately) and discards any pending config.

## Timing
- All outputs are registered. An and seg_sel change only on clk edges; reset is the only asynchronous exception.
- Slot = TICKS_PER_SLOT cycles: BLANK_TICKS blank cycles, then TICKS_PER_SLOT-BLANK_TICKS drive cycles.
- Frame = 8·TICKS_PER_SLOT cycles.
- First cycle after reset release is slot 0 BLANK, tick 0. frame_start is not pulsed for this post-reset frame.
- Config latency: a transfer in slot k takes effect at the next slot-0 start. Worst case is one frame.
- cfg_ready falls in the cycle after a transfer. It rises in the cycle after the frame boundary that consumes the pending entry.
- `tick` width = $clog2(TICKS_PER_SLOT). Compares are unsigned; no overflow is possible.

## Structure
- Package `display_pkg` holds:
  - NUM_DIGITS = 8
  - BRIGHT_MAX = 15
  - PWM_PERIOD = 15
  - phase enum {BLANK, DRIVE}
  - the constant AN_OFF = 8'hFF
- One sub-module, `dimmer_pwm`: mod-15 counter with a clear input. It outputs `on = (cnt < bright)`.

## Test plan
Bench parameters: TICKS_PER_SLOT = 20, BLANK_TICKS = 4.
- Reset, then run 160 cycles:
  - seg_sel steps 0..7 every 20 cycles.
  - An is FF for cycles 0–3 of each slot, then FE, FD, … 7F for cycles 4–19.
  - frame_start pulses at cycle 160.
- Config cfg_digit_en = 8'b1010_1010, bright 15, transferred mid-frame:
  - the mask applies from the next slot-0 start.
  - slots 0, 2, 4 and 6 stay FF through DRIVE.
  - cfg_ready is low until the boundary.
- Bright 5:
  - within each DRIVE window, An[slot] is low for 5 of every 15 cycles, starting at DRIVE entry.
  - bright 0 keeps An = FF for the whole frame.
- Two back-to-back configs:
  - the second is held off (cfg_ready = 0) until the first is applied, then accepted.
  - no config is lost or applied early.
- Transfer in the exact 7→0 boundary cycle: the config applies one frame later, not immediately.
- Assert reset during slot 5 DRIVE:
  - An = FF at once, seg_sel = 0.
  - pending config dropped, act_en = FF, act_br = 15 after release.
